lsu_mem_sequencer: RTL

//  Sequences one RV64 load (LD, opcode 7'b0000011) or store (SD, opcode 7'b0100011) at a time.

---
 rtl/riscv_lsu_pkg.sv | 28 ++
 rtl/lsu_timeout_counter.sv | 41 ++++
 rtl/lsu_mem_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_lsu_pkg
//  Description : Shared constants for the RV64 load/store sequencer:
//                opcodes, error codes and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_lsu_pkg;

    // RV64 major opcodes handled by the sequencer (instruction[6:0])
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Error codes reported on err_code_o
    localparam logic [1:0] c_err_none     = 2'b00;
    localparam logic [1:0] c_err_opcode   = 2'b01;
    localparam logic [1:0] c_err_misalign = 2'b10;
    localparam logic [1:0] c_err_timeout  = 2'b11;

    // Sequencer state encoding
    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_calc = 2'd1;
    localparam logic [c_state_w-1:0] c_st_req  = 2'd2;
    localparam logic [c_state_w-1:0] c_st_resp = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lsu_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_timeout_counter
//  Description : Cycle counter bounding how long a memory request may wait
//                for its acknowledge. Saturates at TIMEOUT-1.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                i_clr     - synchronous clear (priority over i_en)
//                i_en      - count one waiting cycle
//                o_expired - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_sequencer
//  Description : Sequences one RV64 LD/SD at a time between the execute stage
//                and data memory: forms rs1+imm, checks opcode/alignment,
//                runs a req/ack handshake bounded by a timeout, and reports
//                load data or an error code back to the core.
//  Ports       : start_i/opcode_i/rs1_val_i/rs2_val_i/imm_i - core request
//                mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  - memory request
//                mem_ack_i/mem_rdata_i                      - memory response
//                busy_o/done_o/load_data_o/err_o/err_code_o - core response
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_sequencer
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [6:0]      opcode_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            err_o,
    output logic [1:0]      err_code_o
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    logic [6:0]      r_opcode;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [XLEN-1:0] r_load_data;
    logic [1:0]      r_code;

    logic [XLEN-1:0] w_addr;
    logic            w_is_ld;
    logic            w_is_st;
    logic            w_misalign;
    logic [1:0]      w_calc_code;
    logic            w_in_req;
    logic            w_expired;

    // Effective address; wrap-around modulo 2^XLEN is intentional.
    assign w_addr  = r_rs1 + r_imm;
    assign w_is_ld = (r_opcode == OPC_LOAD);
    assign w_is_st = (r_opcode == OPC_STORE);
    assign w_in_req = (r_state == c_st_req);

    generate
        if (CHECK_ALIGN) begin : g_align_chk
            assign w_misalign = |w_addr[2:0];
        end else begin : g_align_off
            assign w_misalign = 1'b0;
        end
    endgenerate

    // Opcode errors take priority over alignment errors.
    always_comb begin
        w_calc_code = c_err_none;
        if (!(w_is_ld || w_is_st)) begin
            w_calc_code = c_err_opcode;
        end else if (w_misalign) begin
            w_calc_code = c_err_misalign;
        end
    end

    // Counter only runs while a request is outstanding, so it restarts at 0
    // for every access. Expiry in a cycle that also sees ack loses to the ack.
    lsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_in_req),
        .i_en      (w_in_req && !mem_ack_i),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start_i) begin
                    w_state_nxt = c_st_calc;
                end
            end
            c_st_calc: begin
                if (w_calc_code != c_err_none) begin
                    w_state_nxt = c_st_resp;
                end else begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                if (mem_ack_i || w_expired) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Operand capture, address registration and result code tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_rs1    <= '0;
            r_imm    <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_code   <= c_err_none;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_opcode <= opcode_i;
                        r_rs1    <= rs1_val_i;
                        r_imm    <= imm_i;
                        r_wdata  <= rs2_val_i;
                        r_code   <= c_err_none;
                    end
                end
                c_st_calc: begin
                    r_addr <= w_addr;
                    r_we   <= w_is_st;
                    r_code <= w_calc_code;
                end
                c_st_req: begin
                    if (mem_ack_i) begin
                        r_code <= c_err_none;
                    end else if (w_expired) begin
                        r_code <= c_err_timeout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only an acknowledged read updates the load data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_data <= '0;
        end else if (w_in_req && mem_ack_i && !r_we) begin
            r_load_data <= mem_rdata_i;
        end
    end

    assign mem_req_o   = w_in_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign busy_o      = (r_state != c_st_idle);
    assign done_o      = (r_state == c_st_resp);
    assign err_o       = done_o && (r_code != c_err_none);
    assign err_code_o  = r_code;
    assign load_data_o = r_load_data;

endmodule
`default_nettype wire
